// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO with show-ahead read data, occupancy count, level flags
// and sticky overflow/underflow error flags.
//
// Parameters
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries (power of two, >= 2)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clock         in   rising-edge clock for all state
//   reset         in   synchronous active-high reset (highest priority)
//   flush         in   synchronous queue clear (pointers and count to zero)
//   data_in       in   write data
//   we            in   write enable
//   re            in   read enable
//   data_out      out  oldest entry, valid combinationally while not empty
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  current occupancy
//   overflow      out  sticky: a write was rejected because the FIFO was full
//   underflow     out  sticky: a read was rejected because the FIFO was empty
//   clear_err     in   clears both sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       we,
    input  logic                       re,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL_C = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_LEVEL_C = CW'(AE_LEVEL);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // Storage and state
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             underflow_r;

    // Decoded flags and per-cycle handshakes
    logic             full_s;
    logic             empty_s;
    logic             wr_accept_s;
    logic             rd_accept_s;
    logic             ovf_event_s;
    logic             und_event_s;
    logic [CW-1:0]    count_next_s;

    // Pointer increment; DEPTH is a power of two so natural overflow wraps
    // DEPTH-1 back to 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return ptr + PTR_ONE;
    endfunction

    // Level flags are pure decodes of the occupancy count.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {CW{1'b0}});
    end

    // Accept/reject decisions for this cycle's requests. A write into a full
    // FIFO is still accepted when a read frees the head slot in the same
    // cycle; a read from an empty FIFO is always rejected, even if a write
    // arrives alongside it.
    always_comb begin
        wr_accept_s = we && (!full_s || re);
        rd_accept_s = re && !empty_s;
        ovf_event_s = we && full_s && !re;
        und_event_s = re && empty_s;
    end

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        count_next_s = count_r;
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_next_s = count_r + COUNT_ONE;
            2'b01:   count_next_s = count_r - COUNT_ONE;
            2'b11:   count_next_s = count_r;
            default: count_next_s = count_r;
        endcase
    end

    // Storage write. Reset and flush suppress the write but leave the array
    // contents untouched, so no reset branch is needed on the data itself.
    always_ff @(posedge clock) begin
        if (!reset && !flush && wr_accept_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers and count: reset > flush > normal traffic.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_accept_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_next_s;
        end
    end

    // Sticky overflow: a new rejected write beats clear_err in the same
    // cycle; a flush neither sets nor clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= overflow_r;
        end else if (ovf_event_s) begin
            overflow_r <= 1'b1;
        end else if (clear_err) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Sticky underflow: same precedence as overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            underflow_r <= 1'b0;
        end else if (flush) begin
            underflow_r <= underflow_r;
        end else if (und_event_s) begin
            underflow_r <= 1'b1;
        end else if (clear_err) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    // Output drive: show-ahead data straight from the head slot, flags
    // decoded from the registered count.
    always_comb begin
        data_out     = mem_r[rd_ptr_r];
        full         = full_s;
        empty        = empty_s;
        almost_full  = (count_r >= AF_LEVEL_C);
        almost_empty = (count_r <= AE_LEVEL_C);
        count        = count_r;
        overflow     = overflow_r;
        underflow    = underflow_r;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Directed self-checking bench for sync_fifo_flags with DEPTH=8, WIDTH=32,
// AF_LEVEL=6, AE_LEVEL=2. Inputs change 1 time unit after each rising edge
// and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [31:0] data_in;
    logic        we;
    logic        re;
    logic [31:0] data_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
    logic        clear_err;

    int tests_run;
    int tests_failed;

    sync_fifo_flags #(
        .WIDTH    (32),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .data_in      (data_in),
        .we           (we),
        .re           (re),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clear_err    (clear_err)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        clear_err = 1'b0;
        data_in   = 32'h0;
    endtask

    task automatic push(input logic [31:0] d);
        we      = 1'b1;
        data_in = d;
        tick();
        idle_inputs();
    endtask

    task automatic pop();
        re = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clock        = 1'b0;
        reset        = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_ae", 32'(almost_empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_af", 32'(almost_full), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_unf", 32'(underflow), 32'd0);

        // Fill 0x1..0x8 and track the level flags at every count
        for (int i = 1; i <= 8; i++) begin
            push(32'(i));
            check_eq("fill_count", 32'(count), 32'(i));
            check_eq("fill_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            check_eq("fill_ae", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
            check_eq("fill_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
        end
        check_eq("fill_head", data_out, 32'h1);

        // Overflow: rejected write is dropped, flag is sticky until clear_err
        push(32'hDEAD);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd8);
        tick();
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        clear_err = 1'b1;
        tick();
        idle_inputs();
        check_eq("ovf_clear", 32'(overflow), 32'd0);

        // Drain in order; 0xDEAD must never appear
        for (int i = 1; i <= 8; i++) begin
            check_eq("drain_data", data_out, 32'(i));
            pop();
        end
        check_eq("drain_empty", 32'(empty), 32'd1);
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_unf", 32'(underflow), 32'd0);

        // Simultaneous write+read while empty
        we = 1'b1; re = 1'b1; data_in = 32'h42;
        tick();
        idle_inputs();
        check_eq("empty_wr_count", 32'(count), 32'd1);
        check_eq("empty_wr_data", data_out, 32'h42);
        check_eq("empty_wr_unf", 32'(underflow), 32'd1);
        clear_err = 1'b1;
        tick();
        idle_inputs();
        check_eq("unf_clear", 32'(underflow), 32'd0);
        pop();
        check_eq("empty_wr_drained", 32'(count), 32'd0);

        // Full pass-through: 0x10..0x17, then write 0x99 with a read
        for (int i = 0; i < 8; i++) begin
            push(32'h10 + 32'(i));
        end
        check_eq("pt_full", 32'(full), 32'd1);
        we = 1'b1; re = 1'b1; data_in = 32'h99;
        tick();
        idle_inputs();
        check_eq("pt_count", 32'(count), 32'd8);
        check_eq("pt_ovf", 32'(overflow), 32'd0);
        check_eq("pt_unf", 32'(underflow), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check_eq("pt_data", data_out, 32'h10 + 32'(i));
            pop();
        end
        check_eq("pt_last", data_out, 32'h99);
        check_eq("pt_last_count", 32'(count), 32'd1);
        pop();
        check_eq("pt_empty", 32'(empty), 32'd1);

        // Wrap: 20 single write/read pairs, pointers wrap more than twice
        for (int k = 0; k < 20; k++) begin
            push(32'h100 + 32'(k));
            check_eq("wrap_count1", 32'(count), 32'd1);
            check_eq("wrap_data", data_out, 32'h100 + 32'(k));
            pop();
            check_eq("wrap_count0", 32'(count), 32'd0);
        end

        // New error wins over clear_err in the same cycle
        pop();
        check_eq("unf_set", 32'(underflow), 32'd1);
        re = 1'b1; clear_err = 1'b1;
        tick();
        idle_inputs();
        check_eq("unf_err_wins", 32'(underflow), 32'd1);
        clear_err = 1'b1;
        tick();
        idle_inputs();
        check_eq("unf_cleared", 32'(underflow), 32'd0);

        // Flush with a write in the same cycle
        for (int i = 0; i < 5; i++) begin
            push(32'h200 + 32'(i));
        end
        check_eq("fl_pre_count", 32'(count), 32'd5);
        flush = 1'b1; we = 1'b1; data_in = 32'h77;
        tick();
        idle_inputs();
        check_eq("fl_count", 32'(count), 32'd0);
        check_eq("fl_empty", 32'(empty), 32'd1);
        check_eq("fl_ovf", 32'(overflow), 32'd0);
        check_eq("fl_unf", 32'(underflow), 32'd0);

        // Flush with a read while empty sets no underflow
        flush = 1'b1; re = 1'b1;
        tick();
        idle_inputs();
        check_eq("fl_re_unf", 32'(underflow), 32'd0);

        // Flush keeps a set sticky flag even with clear_err
        for (int i = 0; i < 8; i++) begin
            push(32'h300 + 32'(i));
        end
        push(32'hBAD);
        check_eq("fl2_ovf_set", 32'(overflow), 32'd1);
        flush = 1'b1; clear_err = 1'b1;
        tick();
        idle_inputs();
        check_eq("fl2_count", 32'(count), 32'd0);
        check_eq("fl2_ovf_kept", 32'(overflow), 32'd1);
        check_eq("fl2_head", data_out, 32'h300);

        // Refill three, then reset with traffic present
        for (int i = 0; i < 3; i++) begin
            push(32'h400 + 32'(i));
        end
        check_eq("rf_count", 32'(count), 32'd3);
        check_eq("rf_head", data_out, 32'h400);
        reset = 1'b1; we = 1'b1; re = 1'b1; data_in = 32'h55;
        tick();
        reset = 1'b0;
        idle_inputs();
        check_eq("rst2_count", 32'(count), 32'd0);
        check_eq("rst2_empty", 32'(empty), 32'd1);
        check_eq("rst2_ovf", 32'(overflow), 32'd0);
        check_eq("rst2_unf", 32'(underflow), 32'd0);

        // Normal operation after reset
        push(32'hA5A5);
        check_eq("post_rst_data", data_out, 32'hA5A5);
        check_eq("post_rst_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
